sl_receiver: RTL and testbench

SL_RECEIVER -- requirements
Module: sl_receiver

---
 rtl/sl_pkg.sv | 36 +++
 rtl/sl_line_sync.sv | 40 ++++
 rtl/sl_receiver.sv | 209 ++++++++++++++++++++
 tb/tb_sl_receiver.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sl_pkg.sv
// sl_pkg: shared definitions for the SL receiver.
//   - sl_state_e      : receive FSM states
//   - CFG_*           : config word field positions (10-bit word)
//   - MAX_LEN_DEFAULT : default maximum data bits per word
//   - CFG_RESET       : config value after reset (length 32, freq_mode 0)
//   - ST_*            : bit indices inside the 4-bit status vector
//   - timeout_limit() : inter-edge limit in clk cycles for a freq_mode
package sl_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRxLow = 2'd1,
      StRxGap = 2'd2
   } sl_state_e;

   localparam int unsigned CFG_W        = 10;
   localparam int unsigned CFG_FREQ_MSB = 9;
   localparam int unsigned CFG_FREQ_LSB = 7;
   localparam int unsigned CFG_RSVD_BIT = 6;
   localparam int unsigned CFG_LEN_MSB  = 5;
   localparam int unsigned CFG_LEN_LSB  = 0;

   localparam int unsigned MAX_LEN_DEFAULT = 32;

   localparam logic [CFG_W-1:0] CFG_RESET = 10'h020;

   localparam int unsigned ST_PARITY  = 0;
   localparam int unsigned ST_LENGTH  = 1;
   localparam int unsigned ST_OVERRUN = 2;
   localparam int unsigned ST_TIMEOUT = 3;

   function automatic logic [12:0] timeout_limit(input logic [2:0] freq_mode);
      return 13'd16 << freq_mode;
   endfunction

endpackage

// File: rtl/sl_line_sync.sv
// sl_line_sync: multi-flop synchronizer for one idle-high SL line.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (flops reset to 1)
//   d          : asynchronous line input
//   q          : synchronized line level
//   fall, rise : one-cycle pulses, aligned with q, on synchronized edges
module sl_line_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q,
   output logic fall,
   output logic rise
);

   logic [STAGES-1:0] sync_q, sync_d;
   logic              prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
      prev_d = sync_q[STAGES-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
         prev_q <= 1'b1;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign q    = sync_q[STAGES-1];
   assign fall = prev_q & ~q;
   assign rise = ~prev_q & q;

endmodule

// File: rtl/sl_receiver.sv
// sl_receiver: two-wire SL line-code word receiver.
// A bit is a low phase on one line (sl0 -> 0, sl1 -> 1) followed by both high;
// a low phase in which both lines were low is the stop symbol. A word is
// length data bits MSB first, one odd-parity bit, then stop.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   sl0, sl1          : asynchronous SL lines, idle high
//   wr_config_w       : {freq_mode[2:0], reserved, length[5:0]}
//   wr_config_enable  : config write strobe
//   r_config_w        : config readback (reserved bit reads 0)
//   data_out          : last good word, right-aligned
//   word_ready        : data_out holds an unconsumed word
//   rd_ack            : consume strobe, clears word_ready and status
//   status            : {timeout_err, overrun, length_err, parity_err}, sticky
//   status_changed    : one-cycle pulse when {word_ready, status} changes
// Optional feature: define SL_RX_TIMEOUT_EN to abort a word when no line edge
// arrives within (16 << freq_mode) cycles.
module sl_receiver
   import sl_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned MAX_LEN     = MAX_LEN_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sl0,
   input  logic        sl1,
   input  logic [9:0]  wr_config_w,
   input  logic        wr_config_enable,
   output logic [9:0]  r_config_w,
   output logic [31:0] data_out,
   output logic        word_ready,
   input  logic        rd_ack,
   output logic [3:0]  status,
   output logic        status_changed
);

   // Shift register holds data plus parity; at least 33 bits so data_out can
   // always be taken from [32:1].
   localparam int unsigned SHW = ((MAX_LEN > 32) ? MAX_LEN : 32) + 1;

   logic l0, l1, fall0, fall1, rise0, rise1;

   sl_line_sync #(.STAGES(SYNC_STAGES)) u_sync0 (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (sl0),
      .q    (l0),
      .fall (fall0),
      .rise (rise0)
   );

   sl_line_sync #(.STAGES(SYNC_STAGES)) u_sync1 (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (sl1),
      .q    (l1),
      .fall (fall1),
      .rise (rise1)
   );

   sl_state_e        state_q, state_d;
   logic [5:0]       bit_cnt_q, bit_cnt_d;
   logic [5:0]       len_q, len_d;
   logic [1:0]       acc_q, acc_d;    // {sl1 seen low, sl0 seen low} this phase
   logic [SHW-1:0]   shift_q, shift_d;
   logic [9:0]       cfg_q, cfg_d;
   logic [31:0]      data_q, data_d;
   logic             ready_q, ready_d;
   logic [3:0]       status_q, status_d;
   logic             chg_q, chg_d;

   logic             any_fall, low_end, cnt_ok, tmo_hit;
   logic [1:0]       low_now;

`ifdef SL_RX_TIMEOUT_EN
   logic [12:0]      tmo_q, tmo_d;
   logic [2:0]       freq_q, freq_d;
`endif

   always_comb begin
      cfg_d = cfg_q;
      if (wr_config_enable) begin
         cfg_d               = wr_config_w;
         cfg_d[CFG_RSVD_BIT] = 1'b0;
      end

      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      len_d     = len_q;
      acc_d     = acc_q;
      shift_d   = shift_q;
      data_d    = data_q;
      ready_d   = rd_ack ? 1'b0 : ready_q;
      status_d  = rd_ack ? 4'b0 : status_q;

      any_fall = fall0 | fall1;
      // A low phase ends on the rise that leaves both lines high.
      low_end  = (rise0 | rise1) & l0 & l1;
      low_now  = {~l1, ~l0};
      cnt_ok   = ({1'b0, bit_cnt_q} == ({1'b0, len_q} + 7'd1));
      tmo_hit  = 1'b0;

`ifdef SL_RX_TIMEOUT_EN
      freq_d = freq_q;
      tmo_d  = '0;
      if (state_q != StIdle) begin
         tmo_d   = (any_fall | rise0 | rise1) ? 13'd0 : tmo_q + 13'd1;
         tmo_hit = (tmo_q >= timeout_limit(freq_q));
      end
`endif

      if (tmo_hit) begin
         state_d              = StIdle;
         status_d[ST_TIMEOUT] = 1'b1;
      end else begin
         unique case (state_q)
            StIdle: begin
               // Starting on a fall (not a level) keeps a line still stuck low
               // after an abort from opening a new word.
               if (any_fall) begin
                  state_d   = StRxLow;
                  len_d     = cfg_q[CFG_LEN_MSB:CFG_LEN_LSB];
                  bit_cnt_d = 6'd0;
                  shift_d   = '0;
                  acc_d     = low_now;
`ifdef SL_RX_TIMEOUT_EN
                  freq_d    = cfg_q[CFG_FREQ_MSB:CFG_FREQ_LSB];
`endif
               end
            end
            StRxLow: begin
               acc_d = acc_q | low_now;
               if (low_end) begin
                  if (acc_q == 2'b11) begin
                     state_d = StIdle;
                     if (!cnt_ok) begin
                        status_d[ST_LENGTH] = 1'b1;
                     end else begin
                        data_d  = shift_q[32:1];
                        ready_d = 1'b1;
                        if (ready_q && !rd_ack) status_d[ST_OVERRUN] = 1'b1;
                        if (!(^shift_q)) status_d[ST_PARITY] = 1'b1;
                     end
                  end else begin
                     state_d = StRxGap;
                     if (32'(bit_cnt_q) < MAX_LEN + 1) shift_d = {shift_q[SHW-2:0], acc_q[1]};
                     if (bit_cnt_q != 6'd63) bit_cnt_d = bit_cnt_q + 6'd1;
                  end
               end
            end
            StRxGap: begin
               if (any_fall) begin
                  state_d = StRxLow;
                  acc_d   = low_now;
               end
            end
            default: state_d = StIdle;
         endcase
      end

      chg_d = ({ready_d, status_d} != {ready_q, status_q});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         bit_cnt_q <= 6'd0;
         len_q     <= CFG_RESET[CFG_LEN_MSB:CFG_LEN_LSB];
         acc_q     <= 2'b00;
         shift_q   <= '0;
         cfg_q     <= CFG_RESET;
         data_q    <= 32'd0;
         ready_q   <= 1'b0;
         status_q  <= 4'd0;
         chg_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         len_q     <= len_d;
         acc_q     <= acc_d;
         shift_q   <= shift_d;
         cfg_q     <= cfg_d;
         data_q    <= data_d;
         ready_q   <= ready_d;
         status_q  <= status_d;
         chg_q     <= chg_d;
      end
   end

`ifdef SL_RX_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_q  <= 13'd0;
         freq_q <= 3'd0;
      end else begin
         tmo_q  <= tmo_d;
         freq_q <= freq_d;
      end
   end
`endif

   assign r_config_w     = cfg_q;
   assign data_out       = data_q;
   assign word_ready     = ready_q;
   assign status         = status_q;
   assign status_changed = chg_q;

endmodule

// File: tb/tb_sl_receiver.sv
module tb_sl_receiver;

   localparam int unsigned SYNC = 2;

   logic        clk, rst_n, sl0, sl1, wr_config_enable, rd_ack;
   logic [9:0]  wr_config_w, r_config_w;
   logic [31:0] data_out;
   logic        word_ready;
   logic [3:0]  status;
   logic        status_changed;

   sl_receiver #(.SYNC_STAGES(SYNC), .MAX_LEN(32)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .sl0             (sl0),
      .sl1             (sl1),
      .wr_config_w     (wr_config_w),
      .wr_config_enable(wr_config_enable),
      .r_config_w      (r_config_w),
      .data_out        (data_out),
      .word_ready      (word_ready),
      .rd_ack          (rd_ack),
      .status          (status),
      .status_changed  (status_changed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] data;
      logic        ready;
      logic [3:0]  status;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_e;

   // Reference model of the visible state.
   logic [31:0] m_data;
   logic        m_ready;
   logic [3:0]  m_status;
   int          m_len;
   logic [2:0]  m_freq;

   bit          tx_bits[64];
   int          tx_n;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_state(input string name);
      chk({name, "_data"}, data_out, m_data);
      chk({name, "_ready"}, 32'(word_ready), 32'(m_ready));
      chk({name, "_status"}, 32'(status), 32'(m_status));
   endtask

   task automatic model_update(input logic [31:0] nd, input logic nr, input logic [3:0] ns);
      if ({nr, ns} != {m_ready, m_status}) sb_q.push_back('{data: nd, ready: nr, status: ns});
      m_data   = nd;
      m_ready  = nr;
      m_status = ns;
   endtask

   // Outcome of a stop symbol after tx_n bits with latched length len.
   task automatic model_stop(input int len, input bit ack);
      logic [31:0] d;
      logic        r;
      logic [3:0]  s;
      int          ones;
      d = m_data;
      r = ack ? 1'b0 : m_ready;
      s = ack ? 4'b0 : m_status;
      if (tx_n != len + 1) begin
         s[1] = 1'b1;
      end else begin
         d    = 32'd0;
         ones = 0;
         for (int i = 0; i < len; i++) d = (d << 1) | 32'(tx_bits[i]);
         for (int i = 0; i < tx_n; i++) ones += int'(tx_bits[i]);
         if (r) s[2] = 1'b1;
         r = 1'b1;
         if (ones % 2 == 0) s[0] = 1'b1;
      end
      model_update(d, r, s);
   endtask

   // Fill tx_bits with a word; nbits < 0 means the correct count.
   task automatic load_word(input logic [31:0] data, input int len, input bit bad_par,
                            input int nbits);
      int  ones;
      bit  par;
      ones = 0;
      for (int i = 0; i < len; i++) ones += int'(data[i]);
      par  = ((ones % 2) == 0) ^ bad_par;
      tx_n = (nbits < 0) ? len + 1 : nbits;
      for (int i = 0; i < tx_n; i++) begin
         if (i < len) tx_bits[i] = data[len-1-i];
         else if (i == len) tx_bits[i] = par;
         else tx_bits[i] = 1'($urandom_range(1, 0));
      end
   endtask

   task automatic cfg_write(input int len, input logic [2:0] fm);
      @(negedge clk);
      wr_config_w      = {fm, 1'b1, 6'(len)};
      wr_config_enable = 1'b1;
      @(negedge clk);
      wr_config_enable = 1'b0;
      chk("cfg_readback", 32'(r_config_w), 32'({fm, 1'b0, 6'(len)}));
      m_len  = len;
      m_freq = fm;
   endtask

   task automatic do_ack();
      @(negedge clk);
      rd_ack = 1'b1;
      model_update(m_data, 1'b0, 4'b0);
      @(negedge clk);
      rd_ack = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic drive_bit(input bit b, input int lo);
      @(negedge clk);
      if (b) sl1 = 1'b0;
      else sl0 = 1'b0;
      repeat (lo) @(negedge clk);
      sl0 = 1'b1;
      sl1 = 1'b1;
      repeat ($urandom_range(4, 2)) @(negedge clk);
   endtask

   task automatic send_word(input int cfg_at, input int new_len, input int long_at,
                            input bit ack_same);
      int len, lat;
      bit expect_rise;
      len = m_len;
      for (int i = 0; i < tx_n; i++) begin
         if (i == cfg_at) cfg_write(new_len, m_freq);
         drive_bit(tx_bits[i], (i == long_at) ? 40 : int'($urandom_range(4, 2)));
      end
      @(negedge clk);
      if ($urandom_range(1, 0) == 1) begin
         sl0 = 1'b0;
         sl1 = 1'b0;
      end else begin
         sl0 = 1'b0;
         @(negedge clk);
         sl1 = 1'b0;
      end
      repeat ($urandom_range(3, 2)) @(negedge clk);
      expect_rise = (tx_n == len + 1) && !m_ready && !ack_same;
      model_stop(len, ack_same);
      if ($urandom_range(1, 0) == 0) begin
         sl0 = 1'b1;
         @(negedge clk);
      end
      sl0 = 1'b1;
      sl1 = 1'b1;
      if (ack_same) begin
         repeat (SYNC) @(negedge clk);
         rd_ack = 1'b1;
         @(negedge clk);
         rd_ack = 1'b0;
      end else if (expect_rise) begin
         lat = 0;
         for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (word_ready) begin
               lat = k;
               break;
            end
         end
         chk("ready_latency", 32'(lat), 32'(SYNC + 1));
      end
      repeat (SYNC + 4) @(negedge clk);
   endtask

   task automatic do_reset();
      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      @(negedge clk);
      sl0   = 1'b1;
      sl1   = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("rst_data", data_out, 32'd0);
      chk("rst_ready", 32'(word_ready), 32'd0);
      chk("rst_status", 32'(status), 32'd0);
      chk("rst_sc", 32'(status_changed), 32'd0);
      chk("rst_cfg", 32'(r_config_w), 32'h020);
      repeat (2) @(negedge clk);
      rst_n    = 1'b1;
      m_data   = 32'd0;
      m_ready  = 1'b0;
      m_status = 4'd0;
      m_len    = 32;
      m_freq   = 3'd0;
      sb_q.delete();
      repeat (2) @(negedge clk);
   endtask

   // Monitor: every status_changed pulse must match the next expected change.
   always @(negedge clk) begin
      if (rst_n && status_changed) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sc_spurious: got pulse expected none, ready %b status %b at %0t",
                     word_ready, status, $time);
         end else begin
            mon_e = sb_q.pop_front();
            chk("sc_data", data_out, mon_e.data);
            chk("sc_ready", 32'(word_ready), 32'(mon_e.ready));
            chk("sc_status", 32'(status), 32'(mon_e.status));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish by 2ms");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      int          len, nb;
      bit          bad, ack_same;

      rst_n = 1'b0;
      sl0 = 1'b1;
      sl1 = 1'b1;
      rd_ack = 1'b0;
      wr_config_enable = 1'b0;
      wr_config_w = 10'd0;
      tx_n = 0;
      m_data = 32'd0;
      m_ready = 1'b0;
      m_status = 4'd0;
      m_len = 32;
      m_freq = 3'd0;
      rst_n = 1'b1;
      do_reset();

      // Length 8, 8'hA5 with good parity.
      cfg_write(8, 3'd0);
      load_word(32'hA5, 8, 1'b0, -1);
      chk("a5_parity_bit", 32'(tx_bits[8]), 32'd1);
      send_word(-1, 0, -1, 1'b0);
      chk("a5_data", data_out, 32'h0000_00A5);
      chk("a5_ready", 32'(word_ready), 32'd1);
      chk("a5_status", 32'(status), 32'd0);
      chk("a5_one_pulse", 32'(sb_q.size()), 32'd0);

      // Length 32, wrong parity: data still delivered.
      do_ack();
      cfg_write(32, 3'd0);
      load_word(32'hDEAD_BEEF, 32, 1'b1, -1);
      send_word(-1, 0, -1, 1'b0);
      chk("dead_data", data_out, 32'hDEAD_BEEF);
      chk("dead_ready", 32'(word_ready), 32'd1);
      chk("dead_status", 32'(status), 32'b0001);

      // Length 16, only 12 bits.
      do_ack();
      cfg_write(16, 3'd0);
      load_word(32'h1234, 16, 1'b0, 12);
      send_word(-1, 0, -1, 1'b0);
      chk("short_data", data_out, 32'hDEAD_BEEF);
      chk("short_ready", 32'(word_ready), 32'd0);
      chk("short_status", 32'(status), 32'b0010);

      // Overrun, then consume.
      do_ack();
      cfg_write(8, 3'd0);
      load_word(32'h11, 8, 1'b0, -1);
      send_word(-1, 0, -1, 1'b0);
      load_word(32'h22, 8, 1'b0, -1);
      send_word(-1, 0, -1, 1'b0);
      chk("ovr_data", data_out, 32'h22);
      chk("ovr_status", 32'(status), 32'b0100);
      do_ack();
      chk("ack_ready", 32'(word_ready), 32'd0);
      chk("ack_status", 32'(status), 32'd0);

      // Completion with rd_ack in the same cycle.
      load_word(32'h5A, 8, 1'b0, -1);
      send_word(-1, 0, -1, 1'b0);
      load_word(32'hC3, 8, 1'b1, -1);
      send_word(-1, 0, -1, 1'b1);
      chk("same_data", data_out, 32'hC3);
      chk("same_ready", 32'(word_ready), 32'd1);
      chk("same_status", 32'(status), 32'b0001);

      // Stop while idle, then rd_ack with nothing ready.
      do_ack();
      tx_n = 0;
      send_word(-1, 0, -1, 1'b0);
      chk("idle_stop_status", 32'(status), 32'b0010);
      chk("idle_stop_data", data_out, 32'hC3);
      do_ack();
      chk("ack0_status", 32'(status), 32'd0);
      chk("ack0_data", data_out, 32'hC3);

      // Config change mid-word only affects the next word.
      load_word(32'h96, 8, 1'b0, -1);
      send_word(3, 16, -1, 1'b0);
      chk_state("midcfg");
      chk("midcfg_data_abs", data_out, 32'h96);
      do_ack();
      load_word(32'hBEEF, 16, 1'b0, -1);
      send_word(-1, 0, -1, 1'b0);
      chk("len16_data", data_out, 32'hBEEF);

      // Reset mid-word discards the partial word.
      cfg_write(8, 3'd0);
      load_word(32'hFF, 8, 1'b0, -1);
      for (int i = 0; i < 5; i++) drive_bit(tx_bits[i], 2);
      do_reset();
      cfg_write(8, 3'd0);
      load_word(32'h3C, 8, 1'b0, -1);
      send_word(-1, 0, -1, 1'b0);
      chk("rst_word_data", data_out, 32'h3C);
      chk("rst_word_status", 32'(status), 32'd0);
      do_ack();

`ifdef SL_RX_TIMEOUT_EN
      // sl1 held low 20 cycles mid-word aborts the word.
      load_word(32'h0F, 8, 1'b0, -1);
      for (int i = 0; i < 3; i++) drive_bit(tx_bits[i], 2);
      model_update(m_data, m_ready, m_status | 4'b1000);
      @(negedge clk);
      sl1 = 1'b0;
      repeat (20) @(negedge clk);
      sl1 = 1'b1;
      repeat (10) @(negedge clk);
      chk("tmo_status", 32'(status), 32'b1000);
      chk("tmo_ready", 32'(word_ready), 32'd0);
      do_ack();
      load_word(32'h81, 8, 1'b0, -1);
      send_word(-1, 0, -1, 1'b0);
      chk("tmo_after_data", data_out, 32'h81);
      chk("tmo_after_status", 32'(status), 32'd0);
`else
      // A long low phase is accepted; timeout_err never sets.
      load_word(32'hE7, 8, 1'b0, -1);
      send_word(-1, 0, 2, 1'b0);
      chk("long_data", data_out, 32'hE7);
      chk("long_status", 32'(status), 32'd0);
`endif
      do_ack();

      // Randomized traffic.
      for (int it = 0; it < 60; it++) begin
         if ($urandom_range(9, 0) == 0) begin
            do_ack();
         end else begin
            if ($urandom_range(3, 0) == 0)
               cfg_write(int'($urandom_range(32, 0)), 3'($urandom_range(7, 0)));
            len = m_len;
            rd  = $urandom;
            if (len < 32) rd = rd & ((32'h1 << len) - 32'h1);
            bad = ($urandom_range(4, 0) == 0);
            nb  = ($urandom_range(5, 0) == 0) ? int'($urandom_range(len + 3, 0)) : -1;
            ack_same = m_ready && ($urandom_range(3, 0) == 0);
            load_word(rd, len, bad, nb);
            send_word(-1, 0, -1, ack_same);
            chk_state("rand");
         end
      end

      repeat (5) @(negedge clk);
      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
